// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, HI/LO, PC, MDR, INPORT, Y, 64-bit Z, MAR, IR.
// Optional macro DP_BUS_TAPS_EN exposes the BusMuxIn* register observation ports.
module cpu_datapath (
  input  logic        Clock,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        INPORTin,
  input  logic        Zin,
  input  logic        Yin,
  input  logic        MARin,
  input  logic        IRin,
  input  logic        AND,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHIout,
  input  logic        ZLOout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        INPORTout,
  input  logic        Zout,
  input  logic        Yout,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [31:0] Mdatain,
  output logic [31:0] busMuxOut,
  output logic [4:0]  encoderOut,
`ifdef DP_BUS_TAPS_EN
  output logic [31:0] BusMuxInR0,  output logic [31:0] BusMuxInR1,
  output logic [31:0] BusMuxInR2,  output logic [31:0] BusMuxInR3,
  output logic [31:0] BusMuxInR4,  output logic [31:0] BusMuxInR5,
  output logic [31:0] BusMuxInR6,  output logic [31:0] BusMuxInR7,
  output logic [31:0] BusMuxInR8,  output logic [31:0] BusMuxInR9,
  output logic [31:0] BusMuxInR10, output logic [31:0] BusMuxInR11,
  output logic [31:0] BusMuxInR12, output logic [31:0] BusMuxInR13,
  output logic [31:0] BusMuxInR14, output logic [31:0] BusMuxInR15,
  output logic [31:0] BusMuxInHI,
  output logic [31:0] BusMuxInLO,
  output logic [31:0] BusMuxInZhi,
  output logic [31:0] BusMuxInZlo,
  output logic [31:0] BusMuxInPC,
  output logic [31:0] BusMuxInMDR,
  output logic [31:0] BusMuxInInport,
  output logic [31:0] BusMuxInY,
`endif
  input  logic        Clear
);

  logic [31:0] r_gpr [16];
  logic [31:0] r_hi, r_lo, r_pc, r_mdr, r_inport, r_y;
  logic [63:0] r_z;
  logic [31:0] MAR, IR;

  logic [15:0] w_gpr_in;
  logic [23:0] w_src;
  logic [4:0]  w_enc;
  logic [31:0] w_bus;
  logic [63:0] w_z_next;

  assign w_gpr_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign w_src = {Yout, INPORTout, MDRout, PCout, (ZLOout | Zout), ZHIout, LOout, HIout,
                  R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  // Descending scan so the lowest asserted code is the last one written.
  always_comb begin
    w_enc = 5'd31;
    for (int i = 23; i >= 0; i--) begin
      if (w_src[i]) w_enc = 5'(i);
    end
  end

  always_comb begin
    case (w_enc)
      5'd16:   w_bus = r_hi;
      5'd17:   w_bus = r_lo;
      5'd18:   w_bus = r_z[63:32];
      5'd19:   w_bus = r_z[31:0];
      5'd20:   w_bus = r_pc;
      5'd21:   w_bus = r_mdr;
      5'd22:   w_bus = r_inport;
      5'd23:   w_bus = r_y;
      default: w_bus = w_enc[4] ? 32'h0000_0000 : r_gpr[w_enc[3:0]];
    endcase
  end

  always_comb begin
    if (AND)        w_z_next = {32'h0000_0000, r_y & w_bus};
    else if (IncPC) w_z_next = {32'h0000_0000, w_bus + 32'd1};
    else            w_z_next = {32'h0000_0000, w_bus};
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= 32'h0000_0000;
      r_hi     <= 32'h0000_0000;
      r_lo     <= 32'h0000_0000;
      r_pc     <= 32'h0000_0000;
      r_mdr    <= 32'h0000_0000;
      r_inport <= 32'h0000_0000;
      r_y      <= 32'h0000_0000;
      r_z      <= 64'h0;
      MAR      <= 32'h0000_0000;
      IR       <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_gpr_in[i]) r_gpr[i] <= w_bus;
      end
      if (HIin)     r_hi     <= w_bus;
      if (LOin)     r_lo     <= w_bus;
      if (PCin)     r_pc     <= w_bus;
      if (MDRin)    r_mdr    <= Read ? Mdatain : w_bus;
      if (INPORTin) r_inport <= w_bus;
      if (Yin)      r_y      <= w_bus;
      if (Zin)      r_z      <= w_z_next;
      if (MARin)    MAR      <= w_bus;
      if (IRin)     IR       <= w_bus;
    end
  end

  assign busMuxOut  = w_bus;
  assign encoderOut = w_enc;

`ifdef DP_BUS_TAPS_EN
  assign BusMuxInR0  = r_gpr[0];  assign BusMuxInR1  = r_gpr[1];
  assign BusMuxInR2  = r_gpr[2];  assign BusMuxInR3  = r_gpr[3];
  assign BusMuxInR4  = r_gpr[4];  assign BusMuxInR5  = r_gpr[5];
  assign BusMuxInR6  = r_gpr[6];  assign BusMuxInR7  = r_gpr[7];
  assign BusMuxInR8  = r_gpr[8];  assign BusMuxInR9  = r_gpr[9];
  assign BusMuxInR10 = r_gpr[10]; assign BusMuxInR11 = r_gpr[11];
  assign BusMuxInR12 = r_gpr[12]; assign BusMuxInR13 = r_gpr[13];
  assign BusMuxInR14 = r_gpr[14]; assign BusMuxInR15 = r_gpr[15];
  assign BusMuxInHI     = r_hi;
  assign BusMuxInLO     = r_lo;
  assign BusMuxInZhi    = r_z[63:32];
  assign BusMuxInZlo    = r_z[31:0];
  assign BusMuxInPC     = r_pc;
  assign BusMuxInMDR    = r_mdr;
  assign BusMuxInInport = r_inport;
  assign BusMuxInY      = r_y;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath.
module tb_cpu_datapath;

  logic        Clock;
  logic        Clear;
  logic [15:0] rin, rout;
  logic        HIin, LOin, PCin, MDRin, INPORTin, Zin, Yin, MARin, IRin, AND;
  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Zout, Yout;
  logic        Read, IncPC;
  logic [31:0] Mdatain;
  logic [31:0] busMuxOut;
  logic [4:0]  encoderOut;
`ifdef DP_BUS_TAPS_EN
  logic [31:0] tap [24];
`endif

  int checks = 0;
  int fails  = 0;

  cpu_datapath dut (
    .Clock(Clock),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .INPORTin(INPORTin),
    .Zin(Zin), .Yin(Yin), .MARin(MARin), .IRin(IRin), .AND(AND),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .Zout(Zout), .Yout(Yout),
    .Read(Read), .IncPC(IncPC), .Mdatain(Mdatain),
    .busMuxOut(busMuxOut), .encoderOut(encoderOut),
`ifdef DP_BUS_TAPS_EN
    .BusMuxInR0(tap[0]),   .BusMuxInR1(tap[1]),   .BusMuxInR2(tap[2]),   .BusMuxInR3(tap[3]),
    .BusMuxInR4(tap[4]),   .BusMuxInR5(tap[5]),   .BusMuxInR6(tap[6]),   .BusMuxInR7(tap[7]),
    .BusMuxInR8(tap[8]),   .BusMuxInR9(tap[9]),   .BusMuxInR10(tap[10]), .BusMuxInR11(tap[11]),
    .BusMuxInR12(tap[12]), .BusMuxInR13(tap[13]), .BusMuxInR14(tap[14]), .BusMuxInR15(tap[15]),
    .BusMuxInHI(tap[16]), .BusMuxInLO(tap[17]), .BusMuxInZhi(tap[18]), .BusMuxInZlo(tap[19]),
    .BusMuxInPC(tap[20]), .BusMuxInMDR(tap[21]), .BusMuxInInport(tap[22]), .BusMuxInY(tap[23]),
`endif
    .Clear(Clear)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rin = 16'h0; rout = 16'h0;
    HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; MDRin = 1'b0; INPORTin = 1'b0;
    Zin = 1'b0; Yin = 1'b0; MARin = 1'b0; IRin = 1'b0; AND = 1'b0;
    HIout = 1'b0; LOout = 1'b0; ZHIout = 1'b0; ZLOout = 1'b0; PCout = 1'b0;
    MDRout = 1'b0; INPORTout = 1'b0; Zout = 1'b0; Yout = 1'b0;
    Read = 1'b0; IncPC = 1'b0;
  endtask

  // Apply current strobes across one rising edge, then drop them.
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
    #1;
  endtask

  // Memory -> MDR -> Rn, checking the bus during the transfer.
  task automatic load_reg(input int idx, input logic [31:0] val);
    Mdatain = val; Read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1; rin[idx] = 1'b1;
    #1;
    chk("mdr_xfer_enc", 64'(encoderOut), 64'd21);
    chk("mdr_xfer_bus", 64'(busMuxOut), 64'(val));
    tick();
  endtask

  task automatic read_reg(input string tag, input int idx, input logic [31:0] exp);
    rout[idx] = 1'b1;
    #1;
    chk(tag, 64'(busMuxOut), 64'(exp));
    rout[idx] = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    Mdatain = 32'h0;
    Clear = 1'b1;
    #12;
    Clear = 1'b0;
    #1;
    chk("reset_bus", 64'(busMuxOut), 64'h0);
    chk("reset_enc", 64'(encoderOut), 64'd31);
    chk("reset_mar", 64'(dut.MAR), 64'h0);

    load_reg(2, 32'h12);
    load_reg(3, 32'h14);
    load_reg(1, 32'h18);
    read_reg("r2_val", 2, 32'h12);
    read_reg("r3_val", 3, 32'h14);
    read_reg("r1_val", 1, 32'h18);

    load_reg(5, 32'h55);
    rout[5] = 1'b1; PCout = 1'b1;
    #1;
    chk("prio_enc", 64'(encoderOut), 64'd5);
    chk("prio_bus", 64'(busMuxOut), 64'h55);
    idle();
    #1;
    chk("idle_enc", 64'(encoderOut), 64'd31);
    chk("idle_bus", 64'(busMuxOut), 64'h0);

    rout[2] = 1'b1; Yin = 1'b1;
    tick();
    rout[3] = 1'b1; AND = 1'b1; Zin = 1'b1;
    tick();
    ZLOout = 1'b1; rin[1] = 1'b1;
    #1;
    chk("and_zlo_enc", 64'(encoderOut), 64'd19);
    chk("and_zlo_bus", 64'(busMuxOut), 64'h10);
    tick();
    read_reg("and_r1", 1, 32'h10);
    ZHIout = 1'b1;
    #1;
    chk("and_zhi", 64'(busMuxOut), 64'h0);
    idle();
    Zout = 1'b1;
    #1;
    chk("zout_alias_enc", 64'(encoderOut), 64'd19);
    chk("zout_alias_bus", 64'(busMuxOut), 64'h10);
    idle();

    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    tick();
    chk("fetch_mar", 64'(dut.MAR), 64'h0);
    ZLOout = 1'b1;
    #1;
    chk("fetch_zlo", 64'(busMuxOut), 64'h1);
    PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h3091_8000;
    tick();
    PCout = 1'b1;
    #1;
    chk("fetch_pc", 64'(busMuxOut), 64'h1);
    idle();
    MDRout = 1'b1; IRin = 1'b1;
    #1;
    chk("fetch_mdr", 64'(busMuxOut), 64'h3091_8000);
    tick();
    chk("fetch_ir", 64'(dut.IR), 64'h3091_8000);

    Read = 1'b1; Mdatain = 32'hDEAD_BEEF;
    tick();
    MDRout = 1'b1;
    #1;
    chk("read_no_mdrin", 64'(busMuxOut), 64'h3091_8000);
    idle();

    rout[3] = 1'b1; AND = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    tick();
    ZLOout = 1'b1;
    #1;
    chk("and_over_inc", 64'(busMuxOut), 64'h10);
    idle();

    Mdatain = 32'hFFFF_FFFF; Read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1; PCin = 1'b1;
    tick();
    PCout = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    tick();
    chk("wrap_z", dut.r_z, 64'h0);
    ZLOout = 1'b1;
    #1;
    chk("wrap_zlo", 64'(busMuxOut), 64'h0);
    idle();

    load_reg(1, 32'h18);
    read_reg("pre_clear_r1", 1, 32'h18);
    Clear = 1'b1;
    #1;
    Clear = 1'b0;
    chk("clr_ir", 64'(dut.IR), 64'h0);
    chk("clr_z", dut.r_z, 64'h0);
    read_reg("clr_r1", 1, 32'h0);
    PCout = 1'b1;
    #1;
    chk("clr_pc", 64'(busMuxOut), 64'h0);
    idle();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
